// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Consumer end of the hazard/branch signalling path in a 5-stage MIPS
//   pipeline. Turns the load-use stall request and the EXE branch-taken
//   indication into PC / IF/ID write enables, an IF/ID flush and an ID/EX
//   bubble. A taken branch starts a multi-cycle flush sequence. A watchdog
//   counts consecutive stall cycles and latches a sticky timeout.
//
// Parameters
//   FLUSH_CYCLES  total flush cycles per taken branch, branch cycle included (1..7)
//   MAX_STALL     consecutive stall cycles before stall_timeout sets (1..255)
//
// Ports
//   clk              pipeline clock
//   rst              asynchronous, active-high reset
//   load_use_hazard  stall request from hazard detection
//   branch_taken     branch/jump resolved taken in EXE this cycle
//   pc_write_en      1 = PC loads its next value
//   if_id_write_en   1 = IF/ID register captures
//   if_id_flush      1 = IF/ID register loads a NOP
//   id_ex_bubble     1 = ID/EX control bits are zeroed
//   stall_timeout    sticky watchdog error, cleared only by rst
//   in_flush         state is FLUSH (visibility)
//   stall_cycles     (PIPE_PERF_CNT_EN only) count of stall cycles, wraps
//   flush_cycles     (PIPE_PERF_CNT_EN only) count of flush cycles, wraps
//
// Optional feature macro: PIPE_PERF_CNT_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MAX_STALL    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_use_hazard,
    input  logic        branch_taken,
    output logic        pc_write_en,
    output logic        if_id_write_en,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        stall_timeout,
`ifdef PIPE_PERF_CNT_EN
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_cycles,
`endif
    output logic        in_flush
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [8:0] STALL_LIM  = 9'(MAX_STALL);

    state_t     state, state_n;
    logic [2:0] flush_cnt, flush_cnt_n;
    logic [7:0] stall_run, stall_run_n;
    logic       timeout_set;
    logic       stall_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            flush_cnt     <= '0;
            stall_run     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
            stall_run <= stall_run_n;
            if (timeout_set) begin
                stall_timeout <= 1'b1;
            end
        end
    end

    // Outputs depend on rst as well as state so the reset values appear
    // immediately, not at the next edge.
    always_comb begin
        state_n        = state;
        flush_cnt_n    = flush_cnt;
        stall_run_n    = stall_run;
        timeout_set    = 1'b0;
        stall_now      = 1'b0;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;

        if (rst) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        stall_run_n  = '0;
                        if (FLUSH_CYCLES > 1) begin
                            flush_cnt_n = FLUSH_INIT;
                            state_n     = FLUSH;
                        end
                    end else if (load_use_hazard) begin
                        stall_now      = 1'b1;
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_bubble   = 1'b1;
                        if (stall_run != 8'hFF) begin
                            stall_run_n = stall_run + 8'd1;
                        end
                        if (({1'b0, stall_run} + 9'd1) == STALL_LIM) begin
                            timeout_set = 1'b1;
                        end
                    end else begin
                        stall_run_n = '0;
                    end
                end
                FLUSH: begin
                    // Requests here come from wrong-path instructions.
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    stall_run_n  = '0;
                    flush_cnt_n  = flush_cnt - 3'd1;
                    if (flush_cnt == 3'd1) begin
                        state_n = RUN;
                    end
                end
                default: begin
                    state_n = RUN;
                end
            endcase
        end
    end

    assign in_flush = (state == FLUSH);

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall_now) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (if_id_flush) begin
                flush_cycles <= flush_cycles + 16'd1;
            end
        end
    end
`endif

endmodule
